// File: rtl/sha256_msg_feeder_if.sv
// rtl/sha256_msg_feeder_if.sv - byte stream, engine handshake and digest signals of sha256_msg_feeder
interface sha256_msg_feeder_if;
    logic         i_Valid;
    logic [7:0]   i_Byte;
    logic         i_fEnd;
    logic         o_Ready;
    logic [511:0] o_Block;
    logic         o_fStart;
    logic         o_fFirst;
    logic         i_fDone;
    logic [255:0] i_Digest;
    logic [255:0] o_Digest;
    logic         o_fDigestValid;
`ifdef SHA_FEED_ERR_EN
    logic         o_fErr;

    modport slave (
        input  i_Valid, i_Byte, i_fEnd, i_fDone, i_Digest,
        output o_Ready, o_Block, o_fStart, o_fFirst, o_Digest, o_fDigestValid, o_fErr
    );
    modport master (
        output i_Valid, i_Byte, i_fEnd, i_fDone, i_Digest,
        input  o_Ready, o_Block, o_fStart, o_fFirst, o_Digest, o_fDigestValid, o_fErr
    );
`else
    modport slave (
        input  i_Valid, i_Byte, i_fEnd, i_fDone, i_Digest,
        output o_Ready, o_Block, o_fStart, o_fFirst, o_Digest, o_fDigestValid
    );
    modport master (
        output i_Valid, i_Byte, i_fEnd, i_fDone, i_Digest,
        input  o_Ready, o_Block, o_fStart, o_fFirst, o_Digest, o_fDigestValid
    );
`endif
endinterface

// File: rtl/sha256_msg_feeder.sv
// rtl/sha256_msg_feeder.sv - SHA-256 byte-stream padder and block feeder for the compression engine
// Define SHA_FEED_ERR_EN to add the sticky protocol-error flag o_fErr.
module sha256_msg_feeder (
    input  logic               i_Clk,
    input  logic               i_Rst,
    sha256_msg_feeder_if.slave bus
);
    typedef enum logic [2:0] {FILL, SEND, WAIT, PAD, LEN, DONE} state_t;

    state_t       r_State;
    logic [5:0]   r_Idx;
    logic [63:0]  r_Len;
    logic [511:0] r_Block;
    logic [255:0] r_Digest;
    logic         r_Ready;
    logic         r_fStart;
    logic         r_fFirst;
    logic         r_fDigestValid;
    logic         r_fSent;
    logic         r_fFinal;
    logic         r_fPendEnd;
    logic         r_fNeedLen;

    logic         w_Beat;
    logic [8:0]   w_ByteLsb;
    logic [511:0] w_PadBlock;

    assign w_Beat    = bus.i_Valid | bus.i_fEnd;
    assign w_ByteLsb = {6'd63 - r_Idx, 3'b000};

    // Padded view of the current block: 0x80 terminator, zero tail, length if it still fits.
    always_comb begin
        w_PadBlock = r_Block;
        for (int b = 0; b < 64; b++) begin
            if (b == int'(r_Idx))
                w_PadBlock[(63 - b) * 8 +: 8] = 8'h80;
            else if (b > int'(r_Idx))
                w_PadBlock[(63 - b) * 8 +: 8] = 8'h00;
        end
        if (r_Idx <= 6'd55)
            w_PadBlock[63:0] = r_Len;
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_State        <= FILL;
            r_Idx          <= '0;
            r_Len          <= '0;
            r_Block        <= '0;
            r_Digest       <= '0;
            r_Ready        <= 1'b1;
            r_fStart       <= 1'b0;
            r_fFirst       <= 1'b0;
            r_fDigestValid <= 1'b0;
            r_fSent        <= 1'b0;
            r_fFinal       <= 1'b0;
            r_fPendEnd     <= 1'b0;
            r_fNeedLen     <= 1'b0;
        end else begin
            r_fStart <= 1'b0;
            r_fFirst <= 1'b0;
            case (r_State)
                FILL: begin
                    if (w_Beat) begin
                        r_fDigestValid <= 1'b0;
                        if (bus.i_Valid) begin
                            r_Block[w_ByteLsb +: 8] <= bus.i_Byte;
                            r_Idx                   <= r_Idx + 6'd1;
                            r_Len                   <= r_Len + 64'd8;
                        end
                        if (bus.i_Valid && r_Idx == 6'd63) begin
                            r_fPendEnd <= bus.i_fEnd;
                            r_Ready    <= 1'b0;
                            r_fStart   <= 1'b1;
                            r_fFirst   <= ~r_fSent;
                            r_State    <= SEND;
                        end else if (bus.i_fEnd) begin
                            r_Ready <= 1'b0;
                            r_State <= PAD;
                        end
                    end
                end
                PAD: begin
                    r_Block    <= w_PadBlock;
                    r_fFinal   <= (r_Idx <= 6'd55);
                    r_fNeedLen <= (r_Idx > 6'd55);
                    r_fStart   <= 1'b1;
                    r_fFirst   <= ~r_fSent;
                    r_State    <= SEND;
                end
                LEN: begin
                    r_Block  <= {448'd0, r_Len};
                    r_fFinal <= 1'b1;
                    r_fStart <= 1'b1;
                    r_fFirst <= ~r_fSent;
                    r_State  <= SEND;
                end
                SEND: begin
                    r_fSent <= 1'b1;
                    r_State <= WAIT;
                end
                WAIT: begin
                    if (bus.i_fDone) begin
                        if (r_fFinal) begin
                            r_Digest       <= bus.i_Digest;
                            r_fDigestValid <= 1'b1;
                            r_fFinal       <= 1'b0;
                            r_State        <= DONE;
                        end else if (r_fPendEnd) begin
                            r_fPendEnd <= 1'b0;
                            r_Idx      <= '0;
                            r_State    <= PAD;
                        end else if (r_fNeedLen) begin
                            r_fNeedLen <= 1'b0;
                            r_State    <= LEN;
                        end else begin
                            r_Idx   <= '0;
                            r_Ready <= 1'b1;
                            r_State <= FILL;
                        end
                    end
                end
                DONE: begin
                    r_Len   <= '0;
                    r_Idx   <= '0;
                    r_fSent <= 1'b0;
                    r_Ready <= 1'b1;
                    r_State <= FILL;
                end
                default: r_State <= FILL;
            endcase
        end
    end

    assign bus.o_Ready        = r_Ready;
    assign bus.o_Block        = r_Block;
    assign bus.o_fStart       = r_fStart;
    assign bus.o_fFirst       = r_fFirst;
    assign bus.o_Digest       = r_Digest;
    assign bus.o_fDigestValid = r_fDigestValid;

`ifdef SHA_FEED_ERR_EN
    logic r_fErr;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst)
            r_fErr <= 1'b0;
        else if ((w_Beat && !r_Ready) || (bus.i_fDone && r_State != WAIT))
            r_fErr <= 1'b1;
    end

    assign bus.o_fErr = r_fErr;
`endif
endmodule
